// File: rtl/cbx_feedthrough_pipe_if.sv
// Channel feedthrough bus: track data, mask scan chain, register chain and
// pipeline status. The master side drives the inputs; the pipe is the slave.
interface cbx_feedthrough_pipe_if #(
    parameter int CHAN_WIDTH = 20
);
    logic                  config_enable;
    logic                  sc_head_in;
    logic                  sc_head_out;
    logic [CHAN_WIDTH-1:0] chanx_left_in;
    logic [CHAN_WIDTH-1:0] chanx_right_in;
    logic [CHAN_WIDTH-1:0] chanx_right_out;
    logic [CHAN_WIDTH-1:0] chanx_left_out;
    logic                  REG_IN_FEEDTHROUGH;
    logic                  REG_OUT_FEEDTHROUGH;
    logic                  pipe_ready;

    modport master (
        output config_enable, sc_head_in, chanx_left_in, chanx_right_in,
               REG_IN_FEEDTHROUGH,
        input  sc_head_out, chanx_right_out, chanx_left_out,
               REG_OUT_FEEDTHROUGH, pipe_ready
    );

    modport slave (
        input  config_enable, sc_head_in, chanx_left_in, chanx_right_in,
               REG_IN_FEEDTHROUGH,
        output sc_head_out, chanx_right_out, chanx_left_out,
               REG_OUT_FEEDTHROUGH, pipe_ready
    );
endinterface

// File: rtl/cbx_feedthrough_pipe.sv
// Retimed horizontal channel feedthrough.
// Every track goes through a PIPE_DEPTH-deep register chain. With
// CBX_FT_BYPASS_EN defined, a 2*CHAN_WIDTH-bit scan-loaded mask selects
// per-track zero-latency bypass; without it all tracks are always registered
// and the scan chain collapses to a single flop.

// One track: PIPE_DEPTH retiming flops plus the bypass select.
module cbx_ft_track #(
    parameter int PIPE_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic byp,
    output logic q
);
    logic [PIPE_DEPTH-1:0] stg;

    // retiming chain, keeps shifting regardless of config mode
    always_ff @(posedge clk) begin
        if (rst) begin
            stg <= '0;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < PIPE_DEPTH; i++) stg[i] <= stg[i-1];
        end
    end

    assign q = byp ? d : stg[PIPE_DEPTH-1];
endmodule

module cbx_feedthrough_pipe #(
    parameter int CHAN_WIDTH = 20,
    parameter int PIPE_DEPTH = 2
) (
    input logic                   clk,
    input logic                   pReset,
    cbx_feedthrough_pipe_if.slave bus
);
    localparam int          NUM_TRK  = 2 * CHAN_WIDTH;
    localparam logic [2:0]  FILL_MAX = 3'(PIPE_DEPTH);

    generate
        if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
            $error("cbx_feedthrough_pipe: PIPE_DEPTH must be 1..4");
        end
    endgenerate

    // Track vector: low half is right-going (left_in -> right_out),
    // high half left-going, matching the mask bit layout.
    logic [NUM_TRK-1:0] trk_in;
    logic [NUM_TRK-1:0] trk_out;
    logic [NUM_TRK-1:0] byp;
    logic [2:0]         fill;
    logic               reg_ft_q;

    assign trk_in = {bus.chanx_right_in, bus.chanx_left_in};

`ifdef CBX_FT_BYPASS_EN
    logic [NUM_TRK-1:0] mask;

    // bypass mask scan chain; reset wins over shifting
    always_ff @(posedge clk) begin
        if (pReset)                 mask <= '0;
        else if (bus.config_enable) mask <= {mask[NUM_TRK-2:0], bus.sc_head_in};
    end

    assign byp             = mask;
    assign bus.sc_head_out = mask[NUM_TRK-1];
`else
    logic sc_q;

    // without a mask the scan chain is a single pass-through flop
    always_ff @(posedge clk) begin
        if (pReset)                 sc_q <= 1'b0;
        else if (bus.config_enable) sc_q <= bus.sc_head_in;
    end

    assign byp             = '0;
    assign bus.sc_head_out = sc_q;
`endif

    generate
        for (genvar t = 0; t < NUM_TRK; t++) begin : g_trk
            cbx_ft_track #(.PIPE_DEPTH(PIPE_DEPTH)) u_trk (
                .clk (clk),
                .rst (pReset),
                .d   (trk_in[t]),
                .byp (byp[t]),
                .q   (trk_out[t])
            );
        end
    endgenerate

    // outputs are quiet while the mask is being loaded
    assign {bus.chanx_left_out, bus.chanx_right_out} =
        bus.config_enable ? '0 : trk_out;

    // saturating fill count: pipeline holds fresh data once it reaches depth
    always_ff @(posedge clk) begin
        if (pReset || bus.config_enable) fill <= '0;
        else if (fill != FILL_MAX)       fill <= fill + 3'd1;
    end

    assign bus.pipe_ready = (fill == FILL_MAX);

    // independent one-flop register chain
    always_ff @(posedge clk) begin
        if (pReset) reg_ft_q <= 1'b0;
        else        reg_ft_q <= bus.REG_IN_FEEDTHROUGH;
    end

    assign bus.REG_OUT_FEEDTHROUGH = reg_ft_q;
endmodule
